// File: rtl/sha256_stream_core.sv
// SHA-256/224 compression over a stream of padded blocks, UNROLL rounds per clock.
// Latency 64/UNROLL+2 cycles per block; i_blk_valid may stall indefinitely in WAIT_BLK.
module sha256_stream_core #(
    parameter int UNROLL      = 1,
    parameter bit SUPPORT_224 = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_mode,
    input  logic [7:0]   i_N,
    input  logic         i_blk_valid,
    input  logic [511:0] i_blk,
    output logic         o_blk_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [255:0] o_digest
);

    typedef enum logic [2:0] {IDLE, WAIT_BLK, ROUND, UPDATE, DONE} state_t;

    localparam logic [5:0] STEP   = 6'(UNROLL);
    localparam logic [5:0] LAST_T = 6'(64 - UNROLL);

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam logic [2047:0] K_ALL = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] kw(input int idx);
        return K_ALL[2047 - 32*idx -: 32];
    endfunction

    state_t             state_q;
    logic [7:0][31:0]   h_q, wv_q;     // index 0 is H0 / working variable a
    logic [15:0][31:0]  w_q;           // index 0 is W[t]
    logic [5:0]         t_q;
    logic [7:0]         blocks_q;
    logic               mode_q;
    logic               rdy_q, busy_q, done_q, err_q;
    logic [255:0]       digest_q;

    logic [31:0]        ext [16+UNROLL];
    logic [15:0][31:0]  w_d;
    logic [7:0][31:0]   wv_d, h_d;
    logic [255:0]       digest_d;
    logic [31:0]        t1, t2;
    logic               sha224;

    assign sha224 = SUPPORT_224 & mode_q;

    always_comb begin
        t1 = '0;
        t2 = '0;
        for (int j = 0; j < 16; j++) ext[j] = w_q[j];
        // later schedule words in this cycle feed on words produced earlier in the same cycle
        for (int j = 16; j < 16 + UNROLL; j++)
            ext[j] = ssig1(ext[j-2]) + ext[j-7] + ssig0(ext[j-15]) + ext[j-16];
        for (int j = 0; j < 16; j++) w_d[j] = ext[j+UNROLL];
        wv_d = wv_q;
        for (int u = 0; u < UNROLL; u++) begin
            t1 = wv_d[7] + bsig1(wv_d[4]) + ((wv_d[4] & wv_d[5]) ^ (~wv_d[4] & wv_d[6]))
               + kw(int'(t_q) + u) + ext[u];
            t2 = bsig0(wv_d[0]) + ((wv_d[0] & wv_d[1]) ^ (wv_d[0] & wv_d[2]) ^ (wv_d[1] & wv_d[2]));
            wv_d[7] = wv_d[6];
            wv_d[6] = wv_d[5];
            wv_d[5] = wv_d[4];
            wv_d[4] = wv_d[3] + t1;
            wv_d[3] = wv_d[2];
            wv_d[2] = wv_d[1];
            wv_d[1] = wv_d[0];
            wv_d[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
        digest_d = '0;
        for (int i = 0; i < 8; i++)
            digest_d[255 - 32*i -: 32] = (i == 7 && sha224) ? 32'h0 : h_d[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            digest_q <= '0;
            blocks_q <= '0;
            t_q      <= '0;
            mode_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (i_start) begin
                    if (i_N != 8'd0) begin
                        for (int i = 0; i < 8; i++)
                            h_q[i] <= (SUPPORT_224 && i_mode) ? IV224[255 - 32*i -: 32]
                                                              : IV256[255 - 32*i -: 32];
                        mode_q   <= i_mode;
                        blocks_q <= i_N;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= WAIT_BLK;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                WAIT_BLK: if (i_blk_valid) begin
                    for (int j = 0; j < 16; j++) w_q[j] <= i_blk[511 - 32*j -: 32];
                    wv_q    <= h_q;
                    t_q     <= '0;
                    rdy_q   <= 1'b0;
                    state_q <= ROUND;
                end
                ROUND: begin
                    wv_q <= wv_d;
                    w_q  <= w_d;
                    t_q  <= t_q + STEP;
                    if (t_q == LAST_T) state_q <= UPDATE;
                end
                UPDATE: begin
                    h_q      <= h_d;
                    blocks_q <= blocks_q - 8'd1;
                    if (blocks_q != 8'd1) begin
                        rdy_q   <= 1'b1;
                        state_q <= WAIT_BLK;
                    end else begin
                        done_q   <= 1'b1;
                        digest_q <= digest_d;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_blk_ready = rdy_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_digest    = digest_q;

endmodule

// File: doc/sha256_stream_core.md
# sha256_stream_core

Parametrised multi-block SHA-256/SHA-224 compression engine. It replaces the fixed single-round `sha_top` flow, in which the bench has to time each block against an internal counter, with a valid/ready block-input handshake. It also adds a configurable number of rounds per cycle and an optional SHA-224 mode. It sits between the message padder/block buffer and the digest consumer, and accepts already-padded 512-bit blocks.

## Interface
Parameters:
- `UNROLL`, default 1: rounds computed per clock. Legal values are 1, 2, 4, 8.
- `SUPPORT_224`, default 1: when 0, `i_mode` is ignored and every message is hashed as SHA-256.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `i_start`  in  1: one-cycle request to begin a message. Sampled only in IDLE.
- `i_mode`  in  1: 0 = SHA-256, 1 = SHA-224. Latched on an accepted start.
- `i_N`  in  8: number of 512-bit blocks in the message, 1..255. Latched on an accepted start.
- `i_blk_valid`  in  1: `i_blk` holds a block.
- `i_blk`  in  512: padded block. `[511:480]` is W0, big-endian words.
- `o_blk_ready`  out  1: the core accepts a block this cycle.
- `o_busy`  out  1: high in every state except IDLE.
- `o_done`  out  1: one-cycle pulse when the digest is valid.
- `o_err`  out  1: one-cycle pulse when a start is rejected because `i_N`=0.
- `o_digest`  out  256: final hash.

## Operation
The core has five states: IDLE, WAIT_BLK, ROUND, UPDATE, DONE.

- **IDLE**
  - `i_start`=1 and `i_N`≠0: load H0..H7 with the IV for the latched mode, set blocks_left=`i_N`, go to WAIT_BLK.
  - `i_start`=1 and `i_N`=0: pulse `o_err` next cycle, stay in IDLE.
- **WAIT_BLK**
  - `o_blk_ready`=1 in this state only.
  - Handshake is `i_blk_valid` & `o_blk_ready`. On handshake: latch the 16-word schedule window from `i_blk`, load a..h from H, clear the round counter, go to ROUND.
  - `i_blk_valid` low: wait indefinitely; the state is held unchanged.
- **ROUND**
  - Each cycle computes `UNROLL` chained rounds with K[t..t+UNROLL-1].
  - The 16-word W window shifts by `UNROLL` words. W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], all mod 2^32.
  - Exit after 64/`UNROLL` cycles to UPDATE.
- **UPDATE**
  - Hi += working variable, mod 2^32 per word. Decrement blocks_left.
  - If blocks_left is nonzero go to WAIT_BLK, else go to DONE.
  - On entering DONE, register `o_digest`:
    - SHA-256: {H0..H7}.
    - SHA-224: {H0..H6, 32'h0}.
- **DONE**
  - `o_done`=1 for exactly one cycle, then go to IDLE.
  - `o_digest` holds its value until the next DONE or a reset.
- **Ignored inputs**
  - `i_start` outside IDLE is ignored and has no effect on the message in progress.
  - `i_mode` and `i_N` changes after a start has been accepted have no effect.
- **IVs**
  - SHA-256: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - SHA-224: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.

## Timing
- **Reset values:** `o_blk_ready`=0, `o_busy`=0, `o_done`=0, `o_err`=0, `o_digest`=0, state=IDLE.
- **Reset mid-operation:** from any state, the core is back in IDLE on the next cycle with all outputs at reset values. The partial hash is discarded.
- **Start:** a start accepted at cycle T gives state WAIT_BLK and `o_blk_ready`=1 at T+1.
- **Per block:** for a block handshake at cycle B:
  - ROUND occupies B+1 .. B+64/`UNROLL`.
  - UPDATE is at B+64/`UNROLL`+1.
  - At B+64/`UNROLL`+2, either `o_blk_ready`=1 again or `o_done`=1.
- **Block-to-block spacing:** blocks presented back-to-back are spaced 64/`UNROLL`+2 cycles.
  - UNROLL=1: 66 cycles.
  - UNROLL=4: 18 cycles.
- **Message latency:** the last handshake to `o_done` is 64/`UNROLL`+2 cycles.
- **Rejected start:** with `i_N`=0 at cycle T, `o_err`=1 at T+1 only.

## Test plan
- **SHA-256 "abc":** `i_N`=1, block 61626380 0…0 00000018 -> `o_done` 66 cycles after handshake (UNROLL=1), `o_digest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- **SHA-256 two blocks:** `i_N`=2, "abcdbcdecdef…nopq" padded, second block 0…01C0, with `i_blk_valid` dropped for 10 cycles between blocks -> `o_digest`=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
  - No extra `o_done` pulse.
  - `o_blk_ready` stays high throughout the gap.
- **SHA-224 "abc":** `i_mode`=1 -> `o_digest`=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000.
- **SUPPORT_224=0 with `i_mode`=1:** -> SHA-256 "abc" digest.
- **UNROLL=4 and UNROLL=8:** repeat the first two scenarios -> identical digests, `o_done` 18 and 10 cycles after the last handshake respectively.
- **Errors and interruptions:**
  - `i_N`=0 start -> `o_err` pulse, `o_busy` stays 0.
  - `i_start` during ROUND -> ignored, digest still correct.
  - `rst` asserted mid-ROUND -> all outputs 0 next cycle. A following "abc" run then returns the correct digest.
